hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard_sat_counter.sv | 23 ++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared WISC-16 pipeline definitions: register width, opcodes, bypass-select
// encodings and the in-flight pipe-entry record used by hazard_scoreboard.
package wisc_pkg;

  localparam int REG_W = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_BR   = 4'b1100;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             load;
  } pipe_entry_t;

  // The youngest producer (EX) holds the freshest value, so it wins over MEM.
  function automatic logic [1:0] fwd_select(input logic m_ex, input logic m_mem);
    if (m_ex)       return FWD_EXMEM;
    else if (m_mem) return FWD_MEMWB;
    else            return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bus: operand/destination info in, stall and bypass selects out.
interface hazard_scoreboard_if #(parameter int CNT_W = 16);
  import wisc_pkg::*;

  // No valid/ready pair: id_valid qualifies the decode fields every cycle and
  // stall is the only back-pressure; decode must hold its instruction while stall=1.
  logic [REG_W-1:0] readReg_1;
  logic [REG_W-1:0] readReg_2;
  logic             rd1_used;
  logic             rd2_used;
  logic [REG_W-1:0] writeReg;
  logic             wr_en;
  logic             is_load;
  logic             id_valid;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd1_sel;
  logic [1:0]       fwd2_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output readReg_1, readReg_2, rd1_used, rd2_used, writeReg, wr_en, is_load,
           id_valid, flush,
    input  stall, fwd1_sel, fwd2_sel, stall_cnt
  );

  modport slave (
    input  readReg_1, readReg_2, rd1_used, rd2_used, writeReg, wr_en, is_load,
           id_valid, flush,
    output stall, fwd1_sel, fwd2_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all ones, clears on rst.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the WISC-16 ID stage; tracks EX/MEM destinations.
// Build with WISC_FORWARD_EN defined for load-use-only stalls plus bypass selects.
module hazard_scoreboard
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  pipe_entry_t ex_q, ex_d, mem_q;
  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic hazard, stall, advance;
  logic mem_load_unused;

  assign m1_ex  = bus.rd1_used & bus.id_valid & ex_q.valid  & (ex_q.dest  == bus.readReg_1);
  assign m2_ex  = bus.rd2_used & bus.id_valid & ex_q.valid  & (ex_q.dest  == bus.readReg_2);
  assign m1_mem = bus.rd1_used & bus.id_valid & mem_q.valid & (mem_q.dest == bus.readReg_1);
  assign m2_mem = bus.rd2_used & bus.id_valid & mem_q.valid & (mem_q.dest == bus.readReg_2);

`ifdef WISC_FORWARD_EN
  assign hazard = (m1_ex | m2_ex) & ex_q.load;
`else
  assign hazard = m1_ex | m2_ex | m1_mem | m2_mem;
`endif

  // A taken branch kills the ID instruction, so there is nothing left to hold.
  assign stall   = hazard & ~bus.flush;
  assign advance = ~stall & ~bus.flush;

  always_comb begin
    ex_d = '0;
    if (advance) begin
      ex_d.valid = bus.id_valid & bus.wr_en;
      ex_d.dest  = bus.writeReg;
      ex_d.load  = bus.is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  // WB is not tracked, so nothing downstream consumes the MEM load flag.
  assign mem_load_unused = mem_q.load;

`ifdef WISC_FORWARD_EN
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  always_comb begin
    fwd1_d = FWD_NONE;
    fwd2_d = FWD_NONE;
    if (advance) begin
      fwd1_d = fwd_select(m1_ex, m1_mem);
      fwd2_d = fwd_select(m2_ex, m2_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_q <= FWD_NONE;
      fwd2_q <= FWD_NONE;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign bus.fwd1_sel = fwd1_q;
  assign bus.fwd2_sel = fwd2_q;
`else
  assign bus.fwd1_sel = FWD_NONE;
  assign bus.fwd2_sel = FWD_NONE;
`endif

  assign bus.stall = stall;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (bus.stall_cnt)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus a
// saturation sequence on a narrow-counter instance.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;

  hazard_scoreboard_if #(.CNT_W(16)) bus();
  hazard_scoreboard_if #(.CNT_W(4))  bus_s();

  hazard_scoreboard #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_scoreboard #(.CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        idv;
    logic [2:0]  r1;
    logic        u1;
    logic [2:0]  r2;
    logic        u2;
    logic [2:0]  wr;
    logic        wen;
    logic        ld;
    logic        fl;
    logic        e_stall;
    logic [1:0]  e_f1;
    logic [1:0]  e_f2;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [20:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(input logic rs, idv, input logic [2:0] r1, input logic u1,
                              input logic [2:0] r2, input logic u2, input logic [2:0] wr,
                              input logic wen, ld, fl, input logic s, input logic [1:0] f1,
                              input logic [1:0] f2, input logic [15:0] cnt);
    vec_t v;
    v.rst = rs; v.idv = idv; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
    v.wr = wr; v.wen = wen; v.ld = ld; v.fl = fl;
    v.e_stall = s; v.e_f1 = f1; v.e_f2 = f2; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [1:0] f1, input logic [1:0] f2, input logic [15:0] cnt);
    return mk(0,0, 0,0, 0,0, 0,0,0,0, 0, f1, f2, cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.id_valid  = v.idv;
    bus.readReg_1 = v.r1;
    bus.rd1_used  = v.u1;
    bus.readReg_2 = v.r2;
    bus.rd2_used  = v.u2;
    bus.writeReg  = v.wr;
    bus.wr_en     = v.wen;
    bus.is_load   = v.ld;
    bus.flush     = v.fl;
  endtask

  task automatic drive_sat(input logic idv);
    bus_s.id_valid  = idv;
    bus_s.readReg_1 = 3'd1;
    bus_s.rd1_used  = 1'b1;
    bus_s.readReg_2 = 3'd0;
    bus_s.rd2_used  = 1'b0;
    bus_s.writeReg  = 3'd1;
    bus_s.wr_en     = 1'b1;
    bus_s.is_load   = 1'b1;
    bus_s.flush     = 1'b0;
  endtask

  task automatic build_vectors();
`ifdef WISC_FORWARD_EN
    vecs.push_back(idle(0,0,0));
    vecs.push_back(mk(0,1, 1,1, 2,1, 3,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 3,1, 2,1, 1,1,0,0, 0,0,0,0));
    vecs.push_back(idle(1,0,0));
    vecs.push_back(idle(0,0,0));
    vecs.push_back(mk(0,1, 6,1, 0,0, 4,1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 0,0,0,1));
    vecs.push_back(idle(2,0,1));
    vecs.push_back(idle(0,0,1));
    vecs.push_back(mk(0,1, 1,1, 2,1, 0,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 0,1, 0,0, 7,1,0,0, 0,0,0,1));
    vecs.push_back(idle(1,0,1));
    vecs.push_back(idle(0,0,1));
    vecs.push_back(mk(0,1, 1,1, 2,1, 6,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 1,1, 2,1, 6,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 6,1, 6,1, 7,0,0,0, 0,0,0,1));
    vecs.push_back(idle(1,1,1));
    vecs.push_back(mk(0,1, 1,1, 1,0, 2,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 1,1, 1,0, 5,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 5,1, 2,1, 0,0,0,0, 0,0,0,1));
    vecs.push_back(idle(1,2,1));
    vecs.push_back(idle(0,0,1));
    vecs.push_back(mk(0,1, 1,1, 1,0, 3,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 3,1, 0,0, 7,1,0,1, 0,0,0,1));
    vecs.push_back(mk(0,1, 7,1, 0,0, 0,0,0,0, 0,0,0,1));
    vecs.push_back(idle(0,0,1));
    vecs.push_back(mk(0,1, 1,1, 1,0, 4,1,1,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,1, 0,0,0,1));
    vecs.push_back(idle(0,0,1));
    vecs.push_back(mk(0,1, 1,1, 1,0, 4,1,1,0, 0,0,0,1));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 1,0,0,1));
    vecs.push_back(mk(1,1, 4,1, 0,0, 5,1,0,0, 0,0,0,2));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 0,0,0,0));
    vecs.push_back(idle(0,0,0));
`else
    vecs.push_back(idle(0,0,0));
    vecs.push_back(mk(0,1, 1,1, 2,1, 3,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 3,1, 2,1, 1,1,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1, 3,1, 2,1, 1,1,0,0, 1,0,0,1));
    vecs.push_back(mk(0,1, 3,1, 2,1, 1,1,0,0, 0,0,0,2));
    vecs.push_back(idle(0,0,2));
    vecs.push_back(idle(0,0,2));
    vecs.push_back(mk(0,1, 6,1, 0,0, 4,1,1,0, 0,0,0,2));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 1,0,0,2));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 1,0,0,3));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 0,0,0,4));
    vecs.push_back(idle(0,0,4));
    vecs.push_back(idle(0,0,4));
    vecs.push_back(mk(0,1, 1,1, 2,1, 0,1,0,0, 0,0,0,4));
    vecs.push_back(mk(0,1, 0,1, 0,0, 7,1,0,0, 1,0,0,4));
    vecs.push_back(mk(0,1, 0,1, 0,0, 7,1,0,0, 1,0,0,5));
    vecs.push_back(mk(0,1, 0,1, 0,0, 7,1,0,0, 0,0,0,6));
    vecs.push_back(idle(0,0,6));
    vecs.push_back(idle(0,0,6));
    vecs.push_back(mk(0,1, 1,1, 2,1, 6,1,0,0, 0,0,0,6));
    vecs.push_back(mk(0,1, 1,1, 6,1, 5,1,0,0, 1,0,0,6));
    vecs.push_back(mk(0,1, 1,1, 6,1, 5,1,0,0, 1,0,0,7));
    vecs.push_back(mk(0,1, 1,1, 6,1, 5,1,0,0, 0,0,0,8));
    vecs.push_back(idle(0,0,8));
    vecs.push_back(idle(0,0,8));
    vecs.push_back(mk(0,1, 0,0, 0,0, 2,1,0,0, 0,0,0,8));
    vecs.push_back(mk(0,1, 2,0, 3,1, 0,0,0,0, 0,0,0,8));
    vecs.push_back(mk(0,0, 2,1, 0,0, 0,0,0,0, 0,0,0,8));
    vecs.push_back(idle(0,0,8));
    vecs.push_back(mk(0,1, 1,1, 2,1, 3,1,0,0, 0,0,0,8));
    vecs.push_back(mk(0,1, 3,1, 0,0, 7,1,0,1, 0,0,0,8));
    vecs.push_back(mk(0,1, 7,1, 0,0, 0,0,0,0, 0,0,0,8));
    vecs.push_back(idle(0,0,8));
    vecs.push_back(mk(0,1, 1,1, 2,1, 4,1,0,0, 0,0,0,8));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 1,0,0,8));
    vecs.push_back(mk(1,1, 4,1, 0,0, 5,1,0,0, 1,0,0,9));
    vecs.push_back(mk(0,1, 4,1, 0,0, 5,1,0,0, 0,0,0,0));
    vecs.push_back(idle(0,0,0));
`endif
  endtask

  initial begin
    logic [20:0] exp;
    logic [3:0]  exp_sat_mid;
    rst = 1'b1;
    drive(idle(0,0,0));
    drive(mk(1,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0));
    drive_sat(1'b0);
    build_vectors();
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      drive(vecs[i]);
      exp_q.push_back({vecs[i].e_stall, vecs[i].e_f1, vecs[i].e_f2, vecs[i].e_cnt});
      @(negedge clk);
      exp = exp_q.pop_front();
      check($sformatf("v%0d stall", i), {31'd0, bus.stall}, {31'd0, exp[20]});
      check($sformatf("v%0d fwd1_sel", i), {30'd0, bus.fwd1_sel}, {30'd0, exp[19:18]});
      check($sformatf("v%0d fwd2_sel", i), {30'd0, bus.fwd2_sel}, {30'd0, exp[17:16]});
      check($sformatf("v%0d stall_cnt", i), {16'd0, bus.stall_cnt}, {16'd0, exp[15:0]});
      @(posedge clk);
    end

    // Back-to-back LD R1,[R1] on the 4-bit-counter instance: counts, then pins at 4'hF.
    #1;
    drive(idle(0,0,0));
    drive_sat(1'b1);
`ifdef WISC_FORWARD_EN
    exp_sat_mid = 4'd3;
`else
    exp_sat_mid = 4'd4;
`endif
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat mid count", {28'd0, bus_s.stall_cnt}, {28'd0, exp_sat_mid});
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("sat full count", {28'd0, bus_s.stall_cnt}, 32'hF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("sat held count", {28'd0, bus_s.stall_cnt}, 32'hF);
    check("sat main untouched", {16'd0, bus.stall_cnt}, 32'd0);

    #1 rst = 1'b1;
    drive_sat(1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("sat after reset", {28'd0, bus_s.stall_cnt}, 32'd0);
    check("sat stall after reset", {31'd0, bus_s.stall}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
